// File: rtl/vx_l1_mem_sched_pkg.sv
// Shared definitions for the socket L1 memory scheduler.
// Provides the arbiter select-width helper and the default widened tag width.
package vx_l1_mem_sched_pkg;

    // Select width for an n-way arbiter; never narrower than one bit.
    function automatic int unsigned arb_sel_bits(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    localparam int unsigned L1_MEM_NUM_INPUTS    = 2;
    localparam int unsigned L1_MEM_TAG_WIDTH     = 8;
    localparam int unsigned L1_MEM_ARB_TAG_WIDTH = L1_MEM_TAG_WIDTH + arb_sel_bits(L1_MEM_NUM_INPUTS);

endpackage

// File: rtl/vx_starve_prio_arb.sv
// Fixed-priority arbiter (index 0 highest) with per-input starvation counters.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   req_valid       raw request valids (a dropped valid clears starvation history)
//   eligible        requests that may be granted this cycle
//   grant_en        a grant may issue this cycle
//   grant_c         one-hot grant (combinational)
//   grant_idx_c     index of the winner (combinational)
//   grant_valid_c   a grant issues this cycle (combinational)
module vx_starve_prio_arb
    import vx_l1_mem_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 2,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned SEL_BITS    = arb_sel_bits(NUM_INPUTS),
    localparam int unsigned CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] req_valid,
    input  logic [NUM_INPUTS-1:0] eligible,
    input  logic                  grant_en,
    output logic [NUM_INPUTS-1:0] grant_c,
    output logic [SEL_BITS-1:0]   grant_idx_c,
    output logic                  grant_valid_c
);

    logic [NUM_INPUTS-1:0][CNT_W-1:0] starve_cnt;
    logic [NUM_INPUTS-1:0][CNT_W-1:0] starve_cnt_nxt;
    logic [NUM_INPUTS-1:0]            starve_hit;

    // Starved inputs override priority (highest starved index wins), else lowest eligible index.
    always_comb begin
        starve_hit = '0;
        for (int i = 1; i < int'(NUM_INPUTS); i++) begin
            starve_hit[i] = eligible[i] && (starve_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
        grant_idx_c = '0;
        if (|starve_hit) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                if (starve_hit[i]) grant_idx_c = SEL_BITS'(i);
            end
        end else begin
            for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
                if (eligible[i]) grant_idx_c = SEL_BITS'(i);
            end
        end
        grant_valid_c = grant_en && (|eligible);
        grant_c       = '0;
        if (grant_valid_c) grant_c[grant_idx_c] = 1'b1;
    end

    // Starvation counters: saturating count of grant cycles lost while eligible.
    always_comb begin
        starve_cnt_nxt = '0;
        for (int i = 1; i < int'(NUM_INPUTS); i++) begin
            starve_cnt_nxt[i] = starve_cnt[i];
            if (!req_valid[i] || grant_c[i]) begin
                starve_cnt_nxt[i] = '0;
            end else if (grant_valid_c && eligible[i] && (starve_cnt[i] != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt_nxt[i] = starve_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_cnt <= '0;
        else        starve_cnt <= starve_cnt_nxt;
    end

endmodule

// File: rtl/vx_l1_mem_sched.sv
// Socket L1 memory scheduler: arbitrates cache line requests onto one memory port,
// tags them with their source, limits outstanding reads, routes responses by tag.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   in_req_*                      per-input request handshake and payload
//   in_rsp_*                      per-input response valid/ready, broadcast data/tag
//   out_req_*                     registered memory request, tag = {in_tag, source}
//   out_rsp_*                     memory response, routed combinationally
module vx_l1_mem_sched
    import vx_l1_mem_sched_pkg::*;
#(
    parameter int unsigned NUM_INPUTS   = 2,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned MAX_PENDING  = 16,
    localparam int unsigned SEL_BITS    = arb_sel_bits(NUM_INPUTS),
    localparam int unsigned ARB_TAG_W   = TAG_WIDTH + SEL_BITS,
    localparam int unsigned BE_W        = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 in_req_valid,
    output logic [NUM_INPUTS-1:0]                 in_req_ready,
    input  logic [NUM_INPUTS-1:0]                 in_req_rw,
    input  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_req_data,
    input  logic [NUM_INPUTS-1:0][BE_W-1:0]       in_req_byteen,
    input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]  in_req_tag,
    output logic [NUM_INPUTS-1:0]                 in_rsp_valid,
    input  logic [NUM_INPUTS-1:0]                 in_rsp_ready,
    output logic [DATA_WIDTH-1:0]                 in_rsp_data,
    output logic [TAG_WIDTH-1:0]                  in_rsp_tag,
    output logic                                  out_req_valid,
    input  logic                                  out_req_ready,
    output logic                                  out_req_rw,
    output logic [ADDR_WIDTH-1:0]                 out_req_addr,
    output logic [DATA_WIDTH-1:0]                 out_req_data,
    output logic [BE_W-1:0]                       out_req_byteen,
    output logic [ARB_TAG_W-1:0]                  out_req_tag,
    input  logic                                  out_rsp_valid,
    output logic                                  out_rsp_ready,
    input  logic [DATA_WIDTH-1:0]                 out_rsp_data,
    input  logic [ARB_TAG_W-1:0]                  out_rsp_tag
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    logic [PEND_W-1:0]     pending;
    logic [NUM_INPUTS-1:0] eligible;
    logic                  grant_en;
    logic [NUM_INPUTS-1:0] grant_c;
    logic [SEL_BITS-1:0]   grant_idx_c;
    logic                  grant_valid_c;
    logic                  rd_grant;
    logic                  rsp_fire;
    logic [SEL_BITS-1:0]   rsp_sel;
    logic                  rsp_route_ok;

    // Registered credit count only, so out_rsp has no combinational path to in_req_ready.
    always_comb begin
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            eligible[i] = in_req_valid[i] && (in_req_rw[i] || (pending < PEND_W'(MAX_PENDING)));
        end
    end

    // Accept only into an empty or draining output register, never while in reset.
    assign grant_en = reset && (!out_req_valid || out_req_ready);

    vx_starve_prio_arb #(
        .NUM_INPUTS   (NUM_INPUTS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (in_req_valid),
        .eligible      (eligible),
        .grant_en      (grant_en),
        .grant_c       (grant_c),
        .grant_idx_c   (grant_idx_c),
        .grant_valid_c (grant_valid_c)
    );

    assign in_req_ready = grant_c;

    // One-entry output register; payload only changes on a new grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_req_valid  <= 1'b0;
            out_req_rw     <= 1'b0;
            out_req_addr   <= '0;
            out_req_data   <= '0;
            out_req_byteen <= '0;
            out_req_tag    <= '0;
        end else if (grant_valid_c) begin
            out_req_valid  <= 1'b1;
            out_req_rw     <= in_req_rw[grant_idx_c];
            out_req_addr   <= in_req_addr[grant_idx_c];
            out_req_data   <= in_req_data[grant_idx_c];
            out_req_byteen <= in_req_byteen[grant_idx_c];
            out_req_tag    <= {in_req_tag[grant_idx_c], grant_idx_c};
        end else if (out_req_ready) begin
            out_req_valid  <= 1'b0;
        end
    end

    // Outstanding-read credits; a response at zero credits leaves the count at zero.
    assign rd_grant = grant_valid_c && !in_req_rw[grant_idx_c];
    assign rsp_fire = out_rsp_valid && out_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (rd_grant && !rsp_fire) begin
            pending <= pending + PEND_W'(1);
        end else if (!rd_grant && rsp_fire && (pending != '0)) begin
            pending <= pending - PEND_W'(1);
        end
    end

    // Response routing by source index; unroutable responses are accepted and dropped.
    assign rsp_sel      = out_rsp_tag[SEL_BITS-1:0];
    assign rsp_route_ok = (32'(rsp_sel) < 32'(NUM_INPUTS));
    assign in_rsp_data  = out_rsp_data;
    assign in_rsp_tag   = out_rsp_tag[ARB_TAG_W-1:SEL_BITS];

    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        if (rsp_route_ok) begin
            in_rsp_valid[rsp_sel] = out_rsp_valid;
            out_rsp_ready         = in_rsp_ready[rsp_sel];
        end
    end

    // Protocol errors from the memory side.
    a_rsp_no_credit: assert property (@(posedge clk) disable iff (!reset)
        rsp_fire |-> (pending != '0));
    a_rsp_bad_route: assert property (@(posedge clk) disable iff (!reset)
        out_rsp_valid |-> rsp_route_ok);

endmodule

// File: tb/tb_vx_l1_mem_sched.sv
`timescale 1ns/1ps
module tb_vx_l1_mem_sched;
    import vx_l1_mem_sched_pkg::*;

    localparam int unsigned N   = 2;
    localparam int unsigned AW  = 26;
    localparam int unsigned DW  = 512;
    localparam int unsigned TW  = 8;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned OTW = L1_MEM_ARB_TAG_WIDTH;
    localparam int unsigned MP  = 16;
    localparam int unsigned SL  = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [N-1:0]          in_req_valid;
    logic [N-1:0]          in_req_ready;
    logic [N-1:0]          in_req_rw;
    logic [N-1:0][AW-1:0]  in_req_addr;
    logic [N-1:0][DW-1:0]  in_req_data;
    logic [N-1:0][BW-1:0]  in_req_byteen;
    logic [N-1:0][TW-1:0]  in_req_tag;
    logic [N-1:0]          in_rsp_valid;
    logic [N-1:0]          in_rsp_ready;
    logic [DW-1:0]         in_rsp_data;
    logic [TW-1:0]         in_rsp_tag;
    logic                  out_req_valid;
    logic                  out_req_ready;
    logic                  out_req_rw;
    logic [AW-1:0]         out_req_addr;
    logic [DW-1:0]         out_req_data;
    logic [BW-1:0]         out_req_byteen;
    logic [OTW-1:0]        out_req_tag;
    logic                  out_rsp_valid;
    logic                  out_rsp_ready;
    logic [DW-1:0]         out_rsp_data;
    logic [OTW-1:0]        out_rsp_tag;

    vx_l1_mem_sched #(
        .NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .STARVE_LIMIT(SL), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_byteen(in_req_byteen),
        .in_req_tag(in_req_tag),
        .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready),
        .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
        .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_byteen(out_req_byteen),
        .out_req_tag(out_req_tag),
        .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready),
        .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [OTW-1:0] tag;
        logic [63:0]   data_lo;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]     req_valid;
        logic [1:0]     req_rw;
        logic           rsp_valid;
        logic [OTW-1:0] rsp_tag;
        logic [1:0]     rsp_ready;
        logic [1:0]     exp_req_ready;
        logic [1:0]     exp_rsp_valid;
        logic [TW-1:0]  exp_rsp_tag;
        logic           exp_out_rsp_ready;
    } vec_t;
    vec_t vecs[6];

    // Starvation / credit reference model state
    int          mc1;
    int          mp;
    int          grants;
    int          first1;
    int          issued0;
    int          issued1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [TW-1:0] tag);
        return 64'hCAFE_0000_0000_0000 | 64'(tag);
    endfunction

    task automatic drive(input int i, input logic v, input logic rw,
                         input logic [TW-1:0] tag, input logic [AW-1:0] addr);
        in_req_valid[i]  = v;
        in_req_rw[i]     = rw;
        in_req_tag[i]    = tag;
        in_req_addr[i]   = addr;
        in_req_data[i]   = {8{data_of(tag)}};
        in_req_byteen[i] = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_req_valid  = '0;
        out_rsp_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // Both inputs held valid; model predicts the grant each cycle.
    task automatic run_grants(input int cycles, input string nm);
        logic [1:0] exp;
        logic [1:0] fired;
        logic       e0, e1, w;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            e0 = in_req_rw[0] || (mp < int'(MP));
            e1 = in_req_rw[1] || (mp < int'(MP));
            exp = 2'b00;
            if (e0 || e1) begin
                w   = (e1 && mc1 == int'(SL)) ? 1'b1 : (e0 ? 1'b0 : 1'b1);
                exp = w ? 2'b10 : 2'b01;
                grants++;
                if (w && first1 == 0) first1 = grants;
                if (w) mc1 = 0;
                else if (e1 && mc1 < int'(SL)) mc1++;
                if (!in_req_rw[w]) mp++;
            end
            check(nm, 64'(in_req_ready), 64'(exp));
            fired = in_req_valid & in_req_ready;
            @(posedge clk);
            #1;
            if (fired[0]) begin
                issued0++;
                drive(0, 1'b1, in_req_rw[0], TW'(issued0), AW'(32'h1000 + issued0));
            end
            if (fired[1]) begin
                issued1++;
                drive(1, 1'b1, in_req_rw[1], TW'(8'h80 + issued1), AW'(32'h2000 + issued1));
            end
        end
    endtask

    // Scoreboard: capture accepted requests, compare against the output register on drain.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_req_valid && out_req_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got tag 0x%0h expected no request", out_req_tag);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("sb_tag",    64'(out_req_tag),        64'(e.tag));
                    check("sb_addr",   64'(out_req_addr),       64'(e.addr));
                    check("sb_rw",     64'(out_req_rw),         64'(e.rw));
                    check("sb_data",   out_req_data[63:0],      e.data_lo);
                    check("sb_byteen", out_req_byteen[63:0],    64'hFFFF_FFFF_FFFF_FFFF);
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (in_req_valid[i] && in_req_ready[i]) begin
                    sb_t s;
                    s.rw      = in_req_rw[i];
                    s.addr    = in_req_addr[i];
                    s.tag     = {in_req_tag[i], 1'(i)};
                    s.data_lo = data_of(in_req_tag[i]);
                    sb_q.push_back(s);
                end
            end
        end
    end

    initial begin
        in_req_valid  = '0;
        in_req_rw     = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_byteen = '0;
        in_req_tag    = '0;
        in_rsp_ready  = '1;
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        out_rsp_tag   = '0;

        vecs[0] = '{2'b00, 2'b00, 1'b0, 9'h000, 2'b11, 2'b00, 2'b00, 8'h00, 1'b1};
        vecs[1] = '{2'b01, 2'b00, 1'b1, 9'h0B4, 2'b01, 2'b01, 2'b01, 8'h5A, 1'b1};
        vecs[2] = '{2'b10, 2'b00, 1'b1, 9'h0B5, 2'b01, 2'b10, 2'b10, 8'h5A, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 1'b1, 9'h1FF, 2'b10, 2'b01, 2'b10, 8'hFF, 1'b1};
        vecs[4] = '{2'b11, 2'b11, 1'b0, 9'h001, 2'b10, 2'b01, 2'b00, 8'h00, 1'b1};
        vecs[5] = '{2'b10, 2'b00, 1'b1, 9'h002, 2'b00, 2'b10, 2'b01, 8'h01, 1'b0};

        // Reset state, with requests already pending
        drive(0, 1'b1, 1'b0, 8'h01, 26'h1);
        drive(1, 1'b1, 1'b0, 8'h02, 26'h2);
        #2;
        check("rst_req_ready", 64'(in_req_ready),  64'h0);
        check("rst_out_valid", 64'(out_req_valid), 64'h0);
        check("rst_pending",   64'(dut.pending),   64'h0);
        in_req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Combinational grant selection and response routing, no clock edge inside a row
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            #1;
            drive(0, vecs[r].req_valid[0], vecs[r].req_rw[0], 8'h10, 26'h10);
            drive(1, vecs[r].req_valid[1], vecs[r].req_rw[1], 8'h20, 26'h20);
            out_rsp_valid = vecs[r].rsp_valid;
            out_rsp_tag   = vecs[r].rsp_tag;
            out_rsp_data  = DW'(64'hF00D_0000 + 64'(r));
            in_rsp_ready  = vecs[r].rsp_ready;
            #1;
            check("vec_req_ready",     64'(in_req_ready),  64'(vecs[r].exp_req_ready));
            check("vec_rsp_valid",     64'(in_rsp_valid),  64'(vecs[r].exp_rsp_valid));
            check("vec_rsp_tag",       64'(in_rsp_tag),    64'(vecs[r].exp_rsp_tag));
            check("vec_out_rsp_ready", 64'(out_rsp_ready), 64'(vecs[r].exp_out_rsp_ready));
            check("vec_rsp_data",      in_rsp_data[63:0],  64'hF00D_0000 + 64'(r));
            in_req_valid  = '0;
            out_rsp_valid = 1'b0;
        end
        in_rsp_ready = '1;

        // Single read: tag 0x5A from input 0 -> 0xB4 on the memory side, response routed back
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 8'h5A, 26'h100);
        @(negedge clk);
        check("a_req_ready", 64'(in_req_ready), 64'h1);
        tick();
        in_req_valid = '0;
        @(negedge clk);
        check("a_out_valid", 64'(out_req_valid), 64'h1);
        check("a_out_tag",   64'(out_req_tag),   64'h0B4);
        check("a_out_addr",  64'(out_req_addr),  64'h100);
        tick();
        check("a_pending", 64'(dut.pending), 64'h1);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = 9'h0B4;
        out_rsp_data  = {8{64'h1234_5678_9ABC_DEF0}};
        in_rsp_ready  = 2'b01;
        #1;
        check("a_rsp_valid",     64'(in_rsp_valid),  64'h1);
        check("a_rsp_tag",       64'(in_rsp_tag),    64'h5A);
        check("a_out_rsp_ready", 64'(out_rsp_ready), 64'h1);
        check("a_rsp_data",      in_rsp_data[63:0],  64'h1234_5678_9ABC_DEF0);
        tick();
        out_rsp_valid = 1'b0;
        in_rsp_ready  = '1;
        check("a_pending_rsp", 64'(dut.pending),   64'h0);
        check("a_out_drained", 64'(out_req_valid), 64'h0);

        // Backpressure: held request stays stable, no new grants
        out_req_ready = 1'b0;
        drive(1, 1'b1, 1'b0, 8'h33, 26'h2AA);
        tick();
        in_req_valid[1] = 1'b0;
        drive(0, 1'b1, 1'b0, 8'h44, 26'h3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b_out_valid", 64'(out_req_valid),   64'h1);
            check("b_out_tag",   64'(out_req_tag),     64'h067);
            check("b_out_addr",  64'(out_req_addr),    64'h2AA);
            check("b_out_data",  out_req_data[63:0],   data_of(8'h33));
            check("b_req_ready", 64'(in_req_ready),    64'h0);
        end
        @(posedge clk);
        #1;
        out_req_ready = 1'b1;
        @(negedge clk);
        check("b_release_ready", 64'(in_req_ready), 64'h1);
        tick();
        in_req_valid = '0;
        @(negedge clk);
        tick();
        do_reset();

        // Starvation: both inputs stream reads; input 1 wins the 9th grant, credits stall at 16
        mc1 = 0; mp = 0; grants = 0; first1 = 0; issued0 = 0; issued1 = 0;
        out_req_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h00, 26'h1000);
        drive(1, 1'b1, 1'b0, 8'h80, 26'h2000);
        run_grants(24, "c_req_ready");
        check("c_first_grant1", 64'(first1), 64'd9);
        check("c_grants",       64'(grants), 64'd16);
        check("c_pending",      64'(dut.pending), 64'd16);

        // Writes keep flowing with credits exhausted
        in_req_rw = 2'b11;
        run_grants(10, "d_req_ready");
        check("d_pending", 64'(dut.pending), 64'd16);
        in_req_valid = '0;

        // Full credits plus a returning response: read still blocked this cycle
        drive(0, 1'b1, 1'b0, 8'h76, 26'h76);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'hAA, 1'b0};
        in_rsp_ready  = '1;
        @(negedge clk);
        check("e_full_blocked",  64'(in_req_ready),  64'h0);
        check("e_out_rsp_ready", 64'(out_rsp_ready), 64'h1);
        tick();
        in_req_valid = '0;
        repeat (8) tick();
        check("e_pending_7", 64'(dut.pending), 64'd7);
        drive(0, 1'b1, 1'b0, 8'h77, 26'h77);
        @(negedge clk);
        check("e_same_cycle_ready", 64'(in_req_ready), 64'h1);
        tick();
        out_rsp_valid = 1'b0;
        in_req_valid  = '0;
        check("e_pending_same", 64'(dut.pending), 64'd7);
        tick();

        // Reset with a held request, then resume
        out_req_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 8'h66, 26'h66);
        tick();
        in_req_valid = '0;
        @(negedge clk);
        check("f_out_valid_held", 64'(out_req_valid), 64'h1);
        drive(1, 1'b1, 1'b1, 8'h65, 26'h65);
        #1 reset = 1'b0;
        #1;
        check("f_out_valid_rst", 64'(out_req_valid), 64'h0);
        check("f_pending_rst",   64'(dut.pending),   64'h0);
        check("f_ready_rst",     64'(in_req_ready),  64'h0);
        in_req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        out_req_ready = 1'b1;
        drive(1, 1'b1, 1'b1, 8'h11, 26'h3);
        @(negedge clk);
        check("f_resume_ready", 64'(in_req_ready), 64'h2);
        tick();
        in_req_valid = '0;
        @(negedge clk);
        check("f_resume_valid", 64'(out_req_valid), 64'h1);
        check("f_resume_tag",   64'(out_req_tag),   64'h023);
        tick();
        check("f_pending_wr", 64'(dut.pending), 64'h0);
        check("sb_empty",     64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
